// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction channel between issuer and alu_sequencer
interface alu_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic [3:0] imm;

  modport master (
    output instr_valid, opcode, rd, rs1, rs2, imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state ADD/SUB/LDI/NOP sequencer over a 4x4-bit register file
module alu_sequencer #(
  parameter logic [3:0] REG_INIT = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  alu_sequencer_if.slave     instr,
  input  logic               clr_ovf,
  output logic               done,
  output logic [3:0]         result,
  output logic               overflow,
  output logic               ovf_sticky,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  state_t     state;
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [1:0] rs1_q;
  logic [1:0] rs2_q;
  logic [3:0] imm_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] rf [4];

  logic [3:0] sum_add;
  logic [3:0] sum_sub;
  logic       ovf_add;
  logic       ovf_sub;

  assign sum_add = a_q + b_q;
  assign sum_sub = a_q + (~b_q + 4'd1);
  assign ovf_add = (a_q[3] == b_q[3]) && (sum_add[3] != a_q[3]);
  assign ovf_sub = (a_q[3] != b_q[3]) && (sum_sub[3] != a_q[3]);

  assign instr.instr_ready = (state == IDLE) && !rst;
  assign busy              = (state != IDLE);

  // result/overflow/done are registered on entry to WB so they are valid while done is high;
  // the register write and sticky flag land on the edge that leaves WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      rd_q       <= 2'd0;
      rs1_q      <= 2'd0;
      rs2_q      <= 2'd0;
      imm_q      <= 4'h0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      done       <= 1'b0;
      result     <= 4'h0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= REG_INIT;
    end else begin
      done <= 1'b0;
      if (clr_ovf) ovf_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (instr.instr_valid) begin
            op_q  <= instr.opcode;
            rd_q  <= instr.rd;
            rs1_q <= instr.rs1;
            rs2_q <= instr.rs2;
            imm_q <= instr.imm;
            state <= READ;
          end
        end
        READ: begin
          a_q   <= rf[rs1_q];
          b_q   <= rf[rs2_q];
          state <= EXEC;
        end
        EXEC: begin
          case (op_q)
            OP_ADD: begin result <= sum_add; overflow <= ovf_add; end
            OP_SUB: begin result <= sum_sub; overflow <= ovf_sub; end
            OP_LDI: begin result <= imm_q;   overflow <= 1'b0;    end
            default: ;
          endcase
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (op_q != OP_NOP) begin
            rf[rd_q] <= result;
            // set wins over a coincident clear
            if (overflow) ovf_sticky <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
